edge_bit_sampler: RTL

Oversampling timing and sampling stage of the UART receiver, directly upstream of the RX FSM. It counts oversampling clock edges within each bit and bits within each frame, providing the `edge_count` and `bit_count` that the FSM uses to sequence states. It also takes a 3-sample majority vote around mid-bit and delivers one voted bit per bit period to the start/parity/stop checkers and the deserializer.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/rx_sync_2ff.sv | 22 ++
 rtl/edge_bit_sampler.sv | 104 ++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: legal oversampling ratios, default widths
// and the 3-input majority vote used by the sampler and the start-check stage.
package uart_rx_pkg;

    localparam logic [4:0] PRESCALE_4  = 5'd4;
    localparam logic [4:0] PRESCALE_8  = 5'd8;
    localparam logic [4:0] PRESCALE_16 = 5'd16;

    localparam int EDGE_W_DEF = 4;
    localparam int BIT_W_DEF  = 5;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Anything that is not an explicitly supported ratio falls back to 16.
    function automatic logic [4:0] decode_prescale(input logic [4:0] value);
        case (value)
            PRESCALE_4: return PRESCALE_4;
            PRESCALE_8: return PRESCALE_8;
            default:    return PRESCALE_16;
        endcase
    endfunction

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchronizer for the serial line; both stages reset to the idle
// level (1) so that reset never looks like a start bit.
module rx_sync_2ff (
    input  logic clk,
    input  logic asy_reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (asy_reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/edge_bit_sampler.sv
// UART RX oversampling counters and mid-bit 3-sample majority voter.
// Define RX_SYNC_EN to insert a two-flop synchronizer on RX_IN.
module edge_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int EDGE_W = EDGE_W_DEF,
    parameter int BIT_W  = BIT_W_DEF
) (
    input  logic              clk,
    input  logic              asy_reset,
    input  logic              RX_IN,
    input  logic [4:0]        prescale,
    input  logic              edge_bit_enable,
    input  logic              data_sampler_enable,
    output logic [EDGE_W-1:0] edge_count,
    output logic [BIT_W-1:0]  bit_count,
    output logic              sampled_bit,
    output logic              sample_valid
);

    logic rx;

`ifdef RX_SYNC_EN
    rx_sync_2ff u_rx_sync (
        .clk       (clk),
        .asy_reset (asy_reset),
        .d         (RX_IN),
        .q         (rx)
    );
`else
    assign rx = RX_IN;
`endif

    logic [4:0]        p_reg;
    logic              enable_q;
    logic              sample_lo;
    logic              sample_mid;
    logic              en_rise;
    logic [EDGE_W-1:0] last_edge;
    logic [EDGE_W-1:0] cap_lo_edge;
    logic [EDGE_W-1:0] cap_mid_edge;
    logic [EDGE_W-1:0] vote_edge;

    // Decision points derive from the latched ratio only, so a prescale change
    // mid-frame cannot shift them.
    assign en_rise      = edge_bit_enable & ~enable_q;
    assign last_edge    = EDGE_W'(p_reg - 5'd1);
    assign cap_lo_edge  = EDGE_W'((p_reg >> 1) - 5'd1);
    assign cap_mid_edge = EDGE_W'(p_reg >> 1);
    assign vote_edge    = EDGE_W'((p_reg >> 1) + 5'd1);

    // NOTE: every register below uses <= so all updates see the same pre-edge
    // values; blocking assignments here would create order-dependent behaviour.
    always_ff @(posedge clk) begin
        if (asy_reset) begin
            p_reg        <= PRESCALE_16;
            enable_q     <= 1'b0;
            edge_count   <= '0;
            bit_count    <= '0;
            sample_lo    <= 1'b1;
            sample_mid   <= 1'b1;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            enable_q     <= edge_bit_enable;
            sample_valid <= 1'b0;

            if (en_rise) begin
                p_reg <= decode_prescale(prescale);
            end

            if (!edge_bit_enable) begin
                // Clearing wins over sampling and throws away any partial vote.
                edge_count <= '0;
                bit_count  <= '0;
                sample_lo  <= 1'b1;
                sample_mid <= 1'b1;
            end else begin
                if (edge_count == last_edge) begin
                    edge_count <= '0;
                    if (bit_count != {BIT_W{1'b1}}) begin
                        bit_count <= bit_count + BIT_W'(1);
                    end
                end else begin
                    edge_count <= edge_count + EDGE_W'(1);
                end

                if (data_sampler_enable) begin
                    if (edge_count == cap_lo_edge) begin
                        sample_lo <= rx;
                    end
                    if (edge_count == cap_mid_edge) begin
                        sample_mid <= rx;
                    end
                    if (edge_count == vote_edge) begin
                        sampled_bit  <= majority3(sample_lo, sample_mid, rx);
                        sample_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
